// File: rtl/p_acc_seq.sv
// Streaming accumulator: sums IN operands in an exact wide register and emits
// one saturated result per group over a valid/ready handshake.
package p_acc_seq_pkg;
  typedef enum logic [0:0] {INT, FXP} dtype_e;
  typedef enum logic [0:0] {Disable, Enable} sign_e;

  typedef struct packed {
    dtype_e      dtype;
    sign_e       sign;
    int unsigned prec;
    int unsigned frac;
  } dconf_t;
endpackage

module p_acc_seq
  import p_acc_seq_pkg::*;
#(
  parameter int unsigned IN   = 5,
  parameter dconf_t      CONF = '{dtype: INT, sign: Enable, prec: 8, frac: 0}
) (
  input  logic                 clk,
  input  logic                 reset_,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CONF.prec-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CONF.prec-1:0] out,
  output logic                 ovf,
  output logic                 udf
);

  localparam int unsigned PREC = CONF.prec;
  localparam int unsigned AW   = PREC + $clog2(IN) + 1;
  localparam int unsigned XW   = AW - PREC;
  localparam int unsigned CW   = $clog2(IN) + 1;
  localparam bit          SGN  = (CONF.sign == Enable);

  localparam logic signed [AW-1:0] S_MAX = {{(XW+1){1'b0}}, {(PREC-1){1'b1}}};
  localparam logic signed [AW-1:0] S_MIN = {{(XW+1){1'b1}}, {(PREC-1){1'b0}}};
  localparam logic signed [AW-1:0] U_MAX = {{XW{1'b0}}, {PREC{1'b1}}};
  localparam logic signed [AW-1:0] MAX_V = SGN ? S_MAX : U_MAX;

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_e;

  state_e                 state_q, state_d;
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PREC-1:0]        out_q, out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   ovf_q, ovf_d;
  logic                   udf_q, udf_d;

  logic signed [AW-1:0]   in_ext;
  logic signed [AW-1:0]   sum;
  logic [PREC-1:0]        sat_out;
  logic                   sat_ovf;
  logic                   sat_udf;
  logic                   accept;

  always_comb begin
    in_ext = SGN ? {{XW{in_data[PREC-1]}}, in_data} : {{XW{1'b0}}, in_data};
    sum    = acc_q + in_ext;
  end

  // The accumulator is wide enough to hold any IN-operand sum, so a single
  // saturation of the final sum is exact. Unsigned sums are never negative.
  always_comb begin
    sat_out = sum[PREC-1:0];
    sat_ovf = 1'b0;
    sat_udf = 1'b0;
    if (sum > MAX_V) begin
      sat_out = MAX_V[PREC-1:0];
      sat_ovf = 1'b1;
    end else if (SGN && (sum < S_MIN)) begin
      sat_out = S_MIN[PREC-1:0];
      sat_udf = 1'b1;
    end
  end

  always_comb begin
    in_ready    = (state_q != DONE);
    accept      = in_valid && in_ready;
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = in_ext;
          cnt_d   = CW'(1);
          state_d = ACC;
        end
      end
      ACC: begin
        if (accept) begin
          acc_d = sum;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(IN - 1)) begin
            state_d     = DONE;
            out_d       = sat_out;
            out_valid_d = 1'b1;
            ovf_d       = sat_ovf;
            udf_d       = sat_udf;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          ovf_d       = 1'b0;
          udf_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over any same-cycle accept or output handshake.
    if (flush) begin
      state_d     = IDLE;
      acc_d       = '0;
      cnt_d       = '0;
      out_d       = '0;
      out_valid_d = 1'b0;
      ovf_d       = 1'b0;
      udf_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign ovf       = ovf_q;
  assign udf       = udf_q;

  a_flags_exclusive: assert property (@(posedge clk) disable iff (!reset_)
    !(ovf_q && udf_q));
  a_flags_only_when_valid: assert property (@(posedge clk) disable iff (!reset_)
    !out_valid_q |-> !(ovf_q || udf_q));
  a_result_held: assert property (@(posedge clk) disable iff (!reset_)
    (out_valid_q && !out_ready && !flush) |=> (out_valid_q && $stable(out_q)
      && $stable(ovf_q) && $stable(udf_q)));

endmodule
